// File: rtl/board_move_ctrl.sv
// Checkers board owner: validates and applies one move per request from the
// player on turn, and answers each accepted request with a one-cycle response.
module board_move_ctrl #(
  parameter bit START_RED = 1'b1,
  parameter int PIECES    = 12
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         new_game,
  input  logic         red_valid,
  output logic         red_ready,
  input  logic [5:0]   red_from,
  input  logic [5:0]   red_to,
  input  logic         green_valid,
  output logic         green_ready,
  input  logic [5:0]   green_from,
  input  logic [5:0]   green_to,
  output logic         resp_valid,
  output logic         resp_ok,
  output logic [2:0]   resp_code,
  output logic         turn_red,
  output logic [3:0]   red_count,
  output logic [3:0]   green_count,
  output logic         game_over,
  output logic [255:0] board_buffer
);

  typedef enum logic [1:0] {IDLE, CHECK, APPLY, RESP} state_t;

  localparam logic [2:0] CODE_OK        = 3'd0;
  localparam logic [2:0] CODE_BAD_SRC   = 3'd1;
  localparam logic [2:0] CODE_DST_OCC   = 3'd2;
  localparam logic [2:0] CODE_GEOMETRY  = 3'd3;
  localparam logic [2:0] CODE_NO_ENEMY  = 3'd4;
  localparam logic [3:0] INIT_COUNT     = 4'(PIECES);

  function automatic logic [255:0] start_position();
    logic [255:0] b;
    b = '0;
    for (int s = 0; s < 64; s++) begin
      if ((((s % 8) + (s / 8)) % 2) == 1) begin
        if ((s / 8) <= 2)      b[4*s +: 4] = 4'b0001;
        else if ((s / 8) >= 5) b[4*s +: 4] = 4'b0011;
      end
    end
    return b;
  endfunction

  localparam logic [255:0] START_BOARD = start_position();

  state_t         state, state_next;
  logic [255:0]   board;
  logic           mover_red;
  logic [5:0]     from_sq, to_sq;
  logic [2:0]     code;

  logic [3:0]        src_nib, dst_nib, mid_nib;
  logic [3:0]        sum_x, sum_y;
  logic [5:0]        mid_sq;
  logic signed [3:0] dx, dy;
  logic [3:0]        adx, ady;
  logic              jump, wrong_way, promote;
  logic [2:0]        check_code;

  assign board_buffer = board;

  // Move decode works on the latched request; the board is stable through CHECK and APPLY.
  assign src_nib   = board[{from_sq, 2'b00} +: 4];
  assign dst_nib   = board[{to_sq, 2'b00} +: 4];
  assign dx        = signed'({1'b0, to_sq[2:0]}) - signed'({1'b0, from_sq[2:0]});
  assign dy        = signed'({1'b0, to_sq[5:3]}) - signed'({1'b0, from_sq[5:3]});
  assign adx       = dx[3] ? unsigned'(-dx) : unsigned'(dx);
  assign ady       = dy[3] ? unsigned'(-dy) : unsigned'(dy);
  assign sum_x     = {1'b0, from_sq[2:0]} + {1'b0, to_sq[2:0]};
  assign sum_y     = {1'b0, from_sq[5:3]} + {1'b0, to_sq[5:3]};
  assign mid_sq    = {sum_y[3:1], sum_x[3:1]};
  assign mid_nib   = board[{mid_sq, 2'b00} +: 4];
  assign jump      = (adx == 4'd2);
  // Red advances toward y=0, green toward y=7; kings may go either way.
  assign wrong_way = ~src_nib[2] & (mover_red ? (dy > 4'sd0) : (dy < 4'sd0));
  assign promote   = mover_red ? (to_sq[5:3] == 3'd0) : (to_sq[5:3] == 3'd7);

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    check_code = CODE_OK;
    if (!src_nib[0] || (src_nib[1] != mover_red))
      check_code = CODE_BAD_SRC;
    else if (dst_nib[0])
      check_code = CODE_DST_OCC;
    else if ((adx != ady) || !((adx == 4'd1) || (adx == 4'd2)) || wrong_way)
      check_code = CODE_GEOMETRY;
    else if (jump && !(mid_nib[0] && (mid_nib[1] != mover_red)))
      check_code = CODE_NO_ENEMY;
  end

  always_comb begin
    state_next  = state;
    red_ready   = 1'b0;
    green_ready = 1'b0;
    case (state)
      IDLE: begin
        red_ready   = turn_red & ~game_over;
        green_ready = ~turn_red & ~game_over;
        if ((red_valid && red_ready) || (green_valid && green_ready))
          state_next = CHECK;
      end
      CHECK:   state_next = APPLY;
      APPLY:   state_next = RESP;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset || new_game) begin
      state       <= IDLE;
      board       <= START_BOARD;
      turn_red    <= START_RED;
      red_count   <= INIT_COUNT;
      green_count <= INIT_COUNT;
      game_over   <= 1'b0;
      resp_valid  <= 1'b0;
      resp_ok     <= 1'b0;
      resp_code   <= CODE_OK;
      mover_red   <= 1'b0;
      from_sq     <= '0;
      to_sq       <= '0;
      code        <= CODE_OK;
    end else begin
      state      <= state_next;
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (red_valid && red_ready) begin
            mover_red <= 1'b1;
            from_sq   <= red_from;
            to_sq     <= red_to;
          end else if (green_valid && green_ready) begin
            mover_red <= 1'b0;
            from_sq   <= green_from;
            to_sq     <= green_to;
          end
        end
        CHECK: code <= check_code;
        APPLY: begin
          resp_valid <= 1'b1;
          resp_ok    <= (code == CODE_OK);
          resp_code  <= code;
          if (code == CODE_OK) begin
            board[{from_sq, 2'b00} +: 4] <= 4'b0000;
            board[{to_sq, 2'b00} +: 4]   <= src_nib | {1'b0, promote, 2'b00};
            turn_red                     <= ~turn_red;
            if (jump) begin
              board[{mid_sq, 2'b00} +: 4] <= 4'b0000;
              if (mover_red) begin
                green_count <= green_count - 4'd1;
                if (green_count == 4'd1) game_over <= 1'b1;
              end else begin
                red_count <= red_count - 4'd1;
                if (red_count == 4'd1) game_over <= 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_board_move_ctrl.sv
// Self-checking bench for board_move_ctrl: directed rule checks plus randomized
// games compared against a square-array model of the checkers rules.
module tb_board_move_ctrl;

  localparam bit START_RED = 1'b1;
  localparam int PIECES    = 12;

  logic         clk = 1'b0;
  logic         reset, new_game;
  logic         red_valid, green_valid;
  logic         red_ready, green_ready;
  logic [5:0]   red_from, red_to, green_from, green_to;
  logic         resp_valid, resp_ok;
  logic [2:0]   resp_code;
  logic         turn_red, game_over;
  logic [3:0]   red_count, green_count;
  logic [255:0] board_buffer;

  int checks = 0;
  int errors = 0;
  int promotions = 0;
  int captured_out = 0;

  // Reference model: one entry per square.
  bit mocc[64], mred[64], mking[64];
  bit mturn, mover;
  int mrc, mgc;

  board_move_ctrl #(.START_RED(START_RED), .PIECES(PIECES)) dut (
    .clk(clk), .reset(reset), .new_game(new_game),
    .red_valid(red_valid), .red_ready(red_ready), .red_from(red_from), .red_to(red_to),
    .green_valid(green_valid), .green_ready(green_ready), .green_from(green_from), .green_to(green_to),
    .resp_valid(resp_valid), .resp_ok(resp_ok), .resp_code(resp_code),
    .turn_red(turn_red), .red_count(red_count), .green_count(green_count),
    .game_over(game_over), .board_buffer(board_buffer)
  );

  always #5 clk = ~clk;

  function automatic void model_start();
    for (int s = 0; s < 64; s++) begin
      int x, y;
      x = s % 8;
      y = s / 8;
      mocc[s]  = ((x + y) % 2 == 1) && (y <= 2 || y >= 5);
      mred[s]  = mocc[s] && (y >= 5);
      mking[s] = 1'b0;
    end
    mturn = START_RED;
    mrc   = PIECES;
    mgc   = PIECES;
    mover = 1'b0;
  endfunction

  function automatic int model_code(bit mr, int f, int t);
    int fx, fy, tx, ty, ddx, ddy, ax, ay, m;
    fx = f % 8; fy = f / 8; tx = t % 8; ty = t / 8;
    ddx = tx - fx; ddy = ty - fy;
    ax = (ddx < 0) ? -ddx : ddx;
    ay = (ddy < 0) ? -ddy : ddy;
    if (!mocc[f] || mred[f] != mr) return 1;
    if (mocc[t]) return 2;
    if (ax != ay || ax < 1 || ax > 2 || (!mking[f] && (mr ? ddy > 0 : ddy < 0))) return 3;
    if (ax == 2) begin
      m = ((fy + ty) / 2) * 8 + (fx + tx) / 2;
      if (!mocc[m] || mred[m] == mr) return 4;
    end
    return 0;
  endfunction

  function automatic void model_apply(bit mr, int f, int t);
    int fx, fy, tx, ty, m;
    fx = f % 8; fy = f / 8; tx = t % 8; ty = t / 8;
    mocc[t] = 1'b1; mred[t] = mred[f]; mking[t] = mking[f];
    mocc[f] = 1'b0; mred[f] = 1'b0; mking[f] = 1'b0;
    if ((tx - fx == 2) || (fx - tx == 2)) begin
      m = ((fy + ty) / 2) * 8 + (fx + tx) / 2;
      mocc[m] = 1'b0; mred[m] = 1'b0; mking[m] = 1'b0;
      if (mr) mgc--; else mrc--;
      if (mrc == 0 || mgc == 0) begin
        mover = 1'b1;
        captured_out++;
      end
    end
    if (!mking[t] && ((mr && ty == 0) || (!mr && ty == 7))) begin
      mking[t] = 1'b1;
      promotions++;
    end
    mturn = !mturn;
  endfunction

  function automatic logic [255:0] model_board();
    logic [255:0] b;
    for (int s = 0; s < 64; s++) b[4*s +: 4] = {1'b0, mking[s], mred[s], mocc[s]};
    return b;
  endfunction

  // Drives one request and observes its response; leaves the caller at the
  // falling edge one cycle after the response pulse.
  task automatic do_move(input bit mr, input logic [5:0] f, input logic [5:0] t,
                         output bit seen, output bit ok, output logic [2:0] code,
                         output int lat, output bit pulse_one);
    int wait_n;
    seen = 0; ok = 0; code = '0; lat = 0; pulse_one = 0;
    @(negedge clk);
    if (mr) begin red_valid = 1; red_from = f; red_to = t; end
    else    begin green_valid = 1; green_from = f; green_to = t; end
    wait_n = 0;
    while (!(mr ? red_ready : green_ready) && wait_n < 20) begin
      @(negedge clk);
      wait_n++;
    end
    if (wait_n >= 20) begin
      red_valid = 0; green_valid = 0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    red_valid = 0; green_valid = 0;
    lat = 1;
    while (!resp_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    if (resp_valid) begin
      seen = 1; ok = resp_ok; code = resp_code;
      @(negedge clk);
      pulse_one = !resp_valid;
    end
  endtask

  task automatic test_reset();
    reset = 0; new_game = 0; red_valid = 0; green_valid = 0;
    red_from = 0; red_to = 0; green_from = 0; green_to = 0;
    repeat (2) @(negedge clk);
    reset = 1;
    model_start();
    @(negedge clk);
    checks += 9;
    if (board_buffer !== model_board()) begin errors++; $display("FAIL reset_board: got %h expected %h", board_buffer, model_board()); end
    if (board_buffer[175:168] !== 8'h03) begin errors++; $display("FAIL reset_nib42: got %h expected 03", board_buffer[175:168]); end
    if (red_ready !== 1'b1) begin errors++; $display("FAIL reset_red_ready: got %b expected 1", red_ready); end
    if (green_ready !== 1'b0) begin errors++; $display("FAIL reset_green_ready: got %b expected 0", green_ready); end
    if (red_count !== 4'd12) begin errors++; $display("FAIL reset_red_count: got %0d expected 12", red_count); end
    if (green_count !== 4'd12) begin errors++; $display("FAIL reset_green_count: got %0d expected 12", green_count); end
    if (game_over !== 1'b0) begin errors++; $display("FAIL reset_game_over: got %b expected 0", game_over); end
    if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b expected 0", resp_valid); end
    if (turn_red !== 1'b1) begin errors++; $display("FAIL reset_turn: got %b expected 1", turn_red); end
  endtask

  task automatic test_first_move();
    bit seen, ok, p1; logic [2:0] code; int lat;
    do_move(1'b1, 6'd42, 6'd35, seen, ok, code, lat, p1);
    model_apply(1'b1, 42, 35);
    checks += 8;
    if (!seen || lat != 3 || !p1) begin errors++; $display("FAIL first_latency: got seen=%0d lat=%0d single=%0d expected 1/3/1", seen, lat, p1); end
    if (ok !== 1'b1 || code !== 3'd0) begin errors++; $display("FAIL first_resp: got ok=%b code=%0d expected ok=1 code=0", ok, code); end
    if (board_buffer[143:140] !== 4'h3) begin errors++; $display("FAIL first_nib35: got %h expected 3", board_buffer[143:140]); end
    if (board_buffer[171:168] !== 4'h0) begin errors++; $display("FAIL first_nib42: got %h expected 0", board_buffer[171:168]); end
    if (turn_red !== 1'b0) begin errors++; $display("FAIL first_turn: got %b expected 0", turn_red); end
    if (red_ready !== 1'b0) begin errors++; $display("FAIL first_red_ready: got %b expected 0", red_ready); end
    if (green_ready !== 1'b1) begin errors++; $display("FAIL first_green_ready: got %b expected 1", green_ready); end
    if (board_buffer !== model_board()) begin errors++; $display("FAIL first_board: got %h expected %h", board_buffer, model_board()); end
  endtask

  task automatic test_reject_codes();
    int tbl_f[6] = '{42, 0, 8, 23, 19, 21};
    int tbl_t[6] = '{33, 9, 17, 22, 37, 39};
    int tbl_c[6] = '{1, 1, 2, 3, 4, 4};
    bit seen, ok, p1; logic [2:0] code; int lat;
    for (int i = 0; i < 6; i++) begin
      do_move(1'b0, 6'(tbl_f[i]), 6'(tbl_t[i]), seen, ok, code, lat, p1);
      checks += 5;
      if (!seen || lat != 3 || !p1) begin errors++; $display("FAIL reject_latency[%0d]: got seen=%0d lat=%0d single=%0d expected 1/3/1", i, seen, lat, p1); end
      if (ok !== 1'b0 || code !== 3'(tbl_c[i])) begin errors++; $display("FAIL reject_code[%0d]: got ok=%b code=%0d expected ok=0 code=%0d", i, ok, code, tbl_c[i]); end
      if (int'(code) != model_code(1'b0, tbl_f[i], tbl_t[i])) begin errors++; $display("FAIL reject_model[%0d]: got %0d expected %0d", i, code, model_code(1'b0, tbl_f[i], tbl_t[i])); end
      if (board_buffer !== model_board()) begin errors++; $display("FAIL reject_board[%0d]: got %h expected %h", i, board_buffer, model_board()); end
      if (turn_red !== 1'b0 || green_ready !== 1'b1) begin errors++; $display("FAIL reject_turn[%0d]: got turn=%b gready=%b expected 0/1", i, turn_red, green_ready); end
    end
  endtask

  task automatic test_new_game();
    bit seen_resp;
    // Abort a green move while it sits in CHECK.
    @(negedge clk);
    green_valid = 1; green_from = 6'd17; green_to = 6'd26;
    @(posedge clk);
    @(negedge clk);
    green_valid = 0;
    new_game = 1;
    @(negedge clk);
    new_game = 0;
    model_start();
    seen_resp = 0;
    for (int i = 0; i < 6; i++) begin
      if (resp_valid) seen_resp = 1;
      @(negedge clk);
    end
    checks += 4;
    if (seen_resp) begin errors++; $display("FAIL abort_resp: got resp_valid=1 expected none"); end
    if (board_buffer !== model_board()) begin errors++; $display("FAIL abort_board: got %h expected %h", board_buffer, model_board()); end
    if (turn_red !== START_RED) begin errors++; $display("FAIL abort_turn: got %b expected %b", turn_red, START_RED); end
    if (red_ready !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b expected 1", red_ready); end
    // new_game wins over a simultaneous accept.
    red_valid = 1; red_from = 6'd42; red_to = 6'd35; new_game = 1;
    @(negedge clk);
    red_valid = 0; new_game = 0;
    seen_resp = 0;
    checks += 1;
    if (red_ready !== 1'b1) begin errors++; $display("FAIL prio_ready: got %b expected 1", red_ready); end
    for (int i = 0; i < 5; i++) begin
      if (resp_valid) seen_resp = 1;
      @(negedge clk);
    end
    checks += 2;
    if (seen_resp) begin errors++; $display("FAIL prio_resp: got resp_valid=1 expected none"); end
    if (board_buffer !== model_board()) begin errors++; $display("FAIL prio_board: got %h expected %h", board_buffer, model_board()); end
  endtask

  task automatic test_random_games();
    bit seen, ok, p1; logic [2:0] code; int lat, exp_code, f, t, r, k;
    int cf[$], ct[$], jf[$], jt[$];
    for (int g = 0; g < 8; g++) begin
      @(negedge clk);
      new_game = 1;
      @(negedge clk);
      new_game = 0;
      model_start();
      for (int mv = 0; mv < 160; mv++) begin
        cf.delete(); ct.delete(); jf.delete(); jt.delete();
        for (int s = 0; s < 64; s++) begin
          if (mocc[s] && mred[s] == mturn) begin
            for (int ddy = -2; ddy <= 2; ddy++) begin
              for (int ddx = -2; ddx <= 2; ddx++) begin
                int nx, ny;
                nx = s % 8 + ddx; ny = s / 8 + ddy;
                if (ddx != 0 && (ddx == ddy || ddx == -ddy) && nx >= 0 && nx < 8 && ny >= 0 && ny < 8 &&
                    model_code(mturn, s, ny * 8 + nx) == 0) begin
                  cf.push_back(s); ct.push_back(ny * 8 + nx);
                  if (ddx == 2 || ddx == -2) begin jf.push_back(s); jt.push_back(ny * 8 + nx); end
                end
              end
            end
          end
        end
        if (cf.size() == 0) break;
        r = $urandom_range(0, 99);
        if (r < 15) begin
          f = $urandom_range(0, 63); t = $urandom_range(0, 63);
        end else if (jf.size() > 0 && r < 85) begin
          k = $urandom_range(0, jf.size() - 1); f = jf[k]; t = jt[k];
        end else begin
          k = $urandom_range(0, cf.size() - 1); f = cf[k]; t = ct[k];
        end
        exp_code = model_code(mturn, f, t);
        do_move(mturn, 6'(f), 6'(t), seen, ok, code, lat, p1);
        if (exp_code == 0) model_apply(mturn, f, t);
        checks += 6;
        if (!seen || lat != 3 || !p1) begin errors++; $display("FAIL rnd_latency g%0d m%0d: got seen=%0d lat=%0d single=%0d expected 1/3/1", g, mv, seen, lat, p1); end
        if (code !== 3'(exp_code) || ok !== (exp_code == 0)) begin errors++; $display("FAIL rnd_resp g%0d m%0d %0d->%0d: got ok=%b code=%0d expected code=%0d", g, mv, f, t, ok, code, exp_code); end
        if (board_buffer !== model_board()) begin errors++; $display("FAIL rnd_board g%0d m%0d: got %h expected %h", g, mv, board_buffer, model_board()); end
        if (turn_red !== mturn) begin errors++; $display("FAIL rnd_turn g%0d m%0d: got %b expected %b", g, mv, turn_red, mturn); end
        if (red_count !== 4'(mrc) || green_count !== 4'(mgc) || game_over !== mover) begin
          errors++; $display("FAIL rnd_counts g%0d m%0d: got %0d/%0d/%b expected %0d/%0d/%b", g, mv, red_count, green_count, game_over, mrc, mgc, mover);
        end
        if (red_ready !== (mturn & !mover) || green_ready !== (!mturn & !mover)) begin
          errors++; $display("FAIL rnd_ready g%0d m%0d: got %b/%b expected %b/%b", g, mv, red_ready, green_ready, mturn & !mover, !mturn & !mover);
        end
        if (mover) break;
      end
    end
    $display("info: random play made %0d promotions and ended %0d games by capture", promotions, captured_out);
  endtask

  initial begin
    test_reset();
    test_first_move();
    test_reject_codes();
    test_new_game();
    test_random_games();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
